// File: rtl/ddr_writer_pkg.sv
// Definitions shared by the DDR layer read and write movers:
// FSM encodings and the layer-config word layout.
package ddr_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_WRITE     = 3'd2,
    ST_INCR      = 3'd3,
    ST_FINISH    = 3'd4
  } ddr_state_e;

  // cfg_i_data layout: {total_bursts, byte_base_address}
  localparam int CFG_FIELD_W    = 32;
  localparam int CFG_ADDR_LSB   = 0;
  localparam int CFG_NBURST_LSB = 32;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_writer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata always shows the head entry.
// Occupancy is tracked in an explicit counter so callers can compare it against chunk sizes.
module sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 512,
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ddr_writer.sv
// Layer writer: buffers the conv output stream and hands it to the DDR write master
// as a series of commands of at most UNIT_BURSTS bursts each.
//
// state      | meaning
// IDLE       | waiting for a layer config word
// WAIT_DATA  | waiting until the FIFO holds the whole next chunk
// WRITE      | command presented to the write master, FIFO drains to m_axis
// INCR       | advance address, retire bursts of the finished command
// FINISH     | layer complete, done pulses on the following cycle
module ddr_writer
  import ddr_writer_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 15,
  parameter int UNIT_BURSTS  = 32,
  parameter int FIFO_DEPTH   = 512
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_i_valid,
  output logic                  cfg_i_ready,
  input  logic [63:0]           cfg_i_data,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tready,
  output logic                  WSTART_REG,
  output logic [31:0]           WADDR_REG,
  output logic [31:0]           WNBURST_REG,
  input  logic                  WDONE_REG,
  output logic                  done
);

  localparam int BEATS_PER_BURST = BURST_LENGTH + 1;
  localparam int BURST_BYTES     = BEATS_PER_BURST * DATA_WIDTH / 8;
  localparam int CNT_W           = $clog2(FIFO_DEPTH + 1);

  ddr_state_e state, state_nxt;

  logic [31:0]      addr_r, rem_r, in_cnt, total_beats, pop_cnt;
  logic [31:0]      nb, chunk_beats, rem_nxt, cfg_nburst;
  logic             cfg_fire, push, pop, done_r;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign cfg_nburst  = cfg_i_data[CFG_NBURST_LSB +: CFG_FIELD_W];
  assign cfg_fire    = cfg_i_valid && cfg_i_ready;
  assign nb          = min_u32(rem_r, 32'(UNIT_BURSTS));
  assign chunk_beats = nb * 32'(BEATS_PER_BURST);
  assign rem_nxt     = rem_r - nb;

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (cfg_fire) state_nxt = (cfg_nburst == '0) ? ST_FINISH : ST_WAIT_DATA;
      ST_WAIT_DATA: if (32'(fifo_count) >= chunk_beats) state_nxt = ST_WRITE;
      ST_WRITE:     if (WDONE_REG) state_nxt = ST_INCR;
      ST_INCR:      state_nxt = (rem_nxt != '0) ? ST_WAIT_DATA : ST_FINISH;
      ST_FINISH:    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_i_ready = 1'b0;
    WSTART_REG  = 1'b0;
    WADDR_REG   = '0;
    WNBURST_REG = '0;
    case (state)
      ST_IDLE:  cfg_i_ready = 1'b1;
      ST_WRITE: begin
        WSTART_REG  = 1'b1;
        WADDR_REG   = addr_r;
        WNBURST_REG = nb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_r      <= '0;
      rem_r       <= '0;
      in_cnt      <= '0;
      total_beats <= '0;
      pop_cnt     <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= (state == ST_FINISH);
      if (cfg_fire) begin
        addr_r      <= cfg_i_data[CFG_ADDR_LSB +: CFG_FIELD_W];
        rem_r       <= cfg_nburst;
        total_beats <= cfg_nburst * 32'(BEATS_PER_BURST);
        in_cnt      <= '0;
      end else if (push) begin
        in_cnt <= in_cnt + 1'b1;
      end
      // An early WDONE still retires the command; pop_cnt restarts for the next one.
      if (state == ST_INCR) begin
        addr_r  <= addr_r + nb * 32'(BURST_BYTES);
        rem_r   <= rem_nxt;
        pop_cnt <= '0;
      end else if (pop) begin
        pop_cnt <= pop_cnt + 1'b1;
      end
    end
  end

  assign done          = done_r;
  assign s_axis_tready = (state != ST_IDLE) && !fifo_full && (in_cnt < total_beats);
  // Never hand the master more beats than the command it was given covers.
  assign m_axis_tvalid = !fifo_empty && (state == ST_WRITE) && (pop_cnt != chunk_beats);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (s_axis_tdata),
    .pop   (pop),
    .rdata (m_axis_tdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ddr_writer.sv
// Directed bench for ddr_writer: table of layer configs with hand-computed command lists,
// plus sequences for early WDONE, reset mid-command and stray config.
`timescale 1ns/1ps
module tb_ddr_writer;

  localparam int DW  = 64;
  localparam int FD  = 512;
  localparam int BPB = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_i_valid = 1'b0;
  logic          cfg_i_ready;
  logic [63:0]   cfg_i_data = '0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tready;
  logic          WSTART_REG;
  logic [31:0]   WADDR_REG;
  logic [31:0]   WNBURST_REG;
  logic          WDONE_REG;
  logic          done;

  ddr_writer #(
    .DATA_WIDTH   (DW),
    .BURST_LENGTH (15),
    .UNIT_BURSTS  (32),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cfg_i_valid   (cfg_i_valid),
    .cfg_i_ready   (cfg_i_ready),
    .cfg_i_data    (cfg_i_data),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .WSTART_REG    (WSTART_REG),
    .WADDR_REG     (WADDR_REG),
    .WNBURST_REG   (WNBURST_REG),
    .WDONE_REG     (WDONE_REG),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      bursts;
    int               gap;
    bit               rand_ready;
    int               ncmd;
    logic [2:0][31:0] exp_addr;
    logic [2:0][31:0] exp_nb;
  } layer_t;

  function automatic layer_t mk(input logic [31:0] addr, input logic [31:0] bursts,
                                input int gap, input bit rr, input int ncmd,
                                input logic [31:0] a0, input logic [31:0] n0,
                                input logic [31:0] a1, input logic [31:0] n1,
                                input logic [31:0] a2, input logic [31:0] n2);
    layer_t v;
    v.addr = addr; v.bursts = bursts; v.gap = gap; v.rand_ready = rr; v.ncmd = ncmd;
    v.exp_addr[0] = a0; v.exp_nb[0] = n0;
    v.exp_addr[1] = a1; v.exp_nb[1] = n1;
    v.exp_addr[2] = a2; v.exp_nb[2] = n2;
    return v;
  endfunction

  // Write-master model and scoreboard state
  bit            rand_ready = 0;
  bit            hold = 0;
  bit            early_done = 0;
  int            occ = 0;
  logic [DW-1:0] sb_q[$];
  int            n_cmd = 0, n_done = 0, done_cyc = 0, hs_cyc = 0, full_hits = 0;
  logic [31:0]   cmd_addr[8], cmd_nb[8];
  int            cmd_occ[8], cmd_beats_log[8];

  initial begin : master
    bit          in_cmd, wdone_sent, push, pop, wdone_nxt, ready_nxt;
    int          cmd_beats;
    logic [31:0] cur_nb;
    in_cmd = 0; wdone_sent = 0; cmd_beats = 0; cur_nb = '0;
    WDONE_REG = 1'b0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      wdone_nxt = 0;
      ready_nxt = 0;
      if (!rstn) begin
        occ = 0;
        sb_q.delete();
        in_cmd = 0;
        wdone_sent = 0;
      end else begin
        if (occ == FD) begin
          full_hits++;
          check("s_tready_while_full", s_axis_tready, 0);
        end
        if (!WSTART_REG) check("m_tvalid_outside_write", m_axis_tvalid, 0);
        if (!WSTART_REG && in_cmd) begin
          in_cmd = 0;
          if (n_cmd >= 1 && n_cmd <= 8) cmd_beats_log[n_cmd-1] = cmd_beats;
        end
        if (WSTART_REG && !in_cmd) begin
          in_cmd = 1; wdone_sent = 0; cmd_beats = 0; cur_nb = WNBURST_REG;
          if (n_cmd < 8) begin
            cmd_addr[n_cmd] = WADDR_REG;
            cmd_nb[n_cmd]   = WNBURST_REG;
            cmd_occ[n_cmd]  = occ;
          end
          n_cmd++;
        end
        if (cfg_i_valid && cfg_i_ready) hs_cyc = cyc;
        if (done) begin
          if (n_done == 0) done_cyc = cyc;
          n_done++;
        end
        push = s_axis_tvalid && s_axis_tready;
        pop  = m_axis_tvalid && m_axis_tready;
        if (pop) begin
          if (sb_q.size() == 0) check("pop_on_empty", 1, 0);
          else check("m_axis_data", m_axis_tdata, sb_q.pop_front());
          cmd_beats++;
        end
        if (push) sb_q.push_back(s_axis_tdata);
        occ = occ + int'(push) - int'(pop);
        if (in_cmd && WSTART_REG && !wdone_sent && !hold &&
            (early_done || cmd_beats == int'(cur_nb) * BPB)) begin
          wdone_nxt = 1;
          wdone_sent = 1;
        end
        ready_nxt = in_cmd && !hold && !early_done && (cmd_beats < int'(cur_nb) * BPB) &&
                    (!rand_ready || ($urandom_range(0, 1) == 1));
      end
      @(posedge clk); #1;
      WDONE_REG = wdone_nxt;
      m_axis_tready = ready_nxt;
    end
  end

  task automatic feed(input int n, input int gap, input int tag);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      s_axis_tdata  = {16'(tag), 16'h0, 32'(i)};
      s_axis_tvalid = 1'b1;
      for (int w = 0; w < 4000 && !ok; w++) begin
        @(negedge clk);
        ok = s_axis_tready;
      end
      if (!ok) begin
        check("s_axis_accept_timeout", 0, 1);
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_cfg(input logic [31:0] addr, input logic [31:0] bursts);
    bit ok = 0;
    @(posedge clk); #1;
    cfg_i_data  = {bursts, addr};
    cfg_i_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cfg_i_ready;
    end
    if (!ok) check("cfg_handshake_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_i_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && n_done == 0; i++) @(posedge clk);
    if (n_done == 0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_wstart(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = WSTART_REG;
    end
    if (!ok) check("wstart_timeout", 0, 1);
  endtask

  task automatic run_layer(input layer_t v, input int idx);
    n_cmd = 0; n_done = 0; full_hits = 0;
    rand_ready = v.rand_ready;
    do_cfg(v.addr, v.bursts);
    fork
      feed(int'(v.bursts) * BPB, v.gap, idx + 1);
      wait_done(20000);
    join
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("v%0d_done_count", idx), n_done, 1);
    check($sformatf("v%0d_cmd_count", idx), n_cmd, v.ncmd);
    for (int k = 0; k < v.ncmd && k < 3; k++) begin
      check($sformatf("v%0d_cmd%0d_addr", idx, k), cmd_addr[k], v.exp_addr[k]);
      check($sformatf("v%0d_cmd%0d_nburst", idx, k), cmd_nb[k], v.exp_nb[k]);
      check($sformatf("v%0d_cmd%0d_beats", idx, k), cmd_beats_log[k], int'(v.exp_nb[k]) * BPB);
      check($sformatf("v%0d_cmd%0d_buffered_before_start", idx, k),
            cmd_occ[k] >= int'(v.exp_nb[k]) * BPB, 1);
    end
    if (v.bursts == 0) check($sformatf("v%0d_done_latency", idx), done_cyc - hs_cyc, 2);
    if (v.rand_ready && v.bursts >= 32) check($sformatf("v%0d_fifo_full_seen", idx), full_hits > 0, 1);
    check($sformatf("v%0d_fifo_drained", idx), sb_q.size(), 0);
    check($sformatf("v%0d_waddr_idle", idx), WADDR_REG, 0);
    check($sformatf("v%0d_cfg_ready_idle", idx), cfg_i_ready, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  layer_t vecs[5];

  initial begin : main
    vecs[0] = mk(32'h0000_1000,  2, 0, 0, 1, 32'h1000, 2, 0, 0, 0, 0);
    vecs[1] = mk(32'h0000_0000, 70, 0, 1, 3, 32'h0000, 32, 32'h1000, 32, 32'h2000, 6);
    vecs[2] = mk(32'h0000_0500,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(32'h0000_4000, 32, 2, 0, 1, 32'h4000, 32, 0, 0, 0, 0);
    vecs[4] = mk(32'hFFFF_F000, 33, 0, 1, 2, 32'hFFFF_F000, 32, 32'h0000_0000, 1, 0, 0);

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", cfg_i_ready, 1);
    check("rst_wstart", WSTART_REG, 0);
    check("rst_waddr", WADDR_REG, 0);
    check("rst_wnburst", WNBURST_REG, 0);
    check("rst_done", done, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) run_layer(vecs[i], i);

    // Early WDONE: command retires with nothing popped and the layer still completes.
    n_cmd = 0; n_done = 0; early_done = 1; rand_ready = 0;
    do_cfg(32'h0000_6000, 1);
    feed(BPB, 0, 40);
    wait_done(500);
    repeat (3) @(posedge clk);
    check("early_wdone_done_count", n_done, 1);
    check("early_wdone_cmd_count", n_cmd, 1);
    check("early_wdone_beats_popped", cmd_beats_log[0], 0);
    early_done = 0;
    @(posedge clk); #1; rstn = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;

    // Reset while a command is in WRITE, with a stray config offered mid-command.
    n_cmd = 0; n_done = 0; hold = 1;
    do_cfg(32'h0000_3000, 1);
    feed(BPB, 0, 50);
    wait_wstart(200);
    @(posedge clk); #1;
    cfg_i_data  = {32'd5, 32'hDEAD_0000};
    cfg_i_valid = 1'b1;
    @(negedge clk);
    check("busy_cfg_ready", cfg_i_ready, 0);
    @(posedge clk); #1;
    cfg_i_valid = 1'b0;
    @(negedge clk);
    check("busy_waddr_kept", WADDR_REG, 32'h3000);
    check("busy_wnburst_kept", WNBURST_REG, 1);
    @(posedge clk); #1; rstn = 1'b0;
    @(posedge clk); #1;
    check("midrst_wstart", WSTART_REG, 0);
    check("midrst_cfg_ready", cfg_i_ready, 1);
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_s_tready", s_axis_tready, 0);
    check("midrst_done", done, 0);
    rstn = 1'b1;
    hold = 0;
    repeat (5) @(posedge clk);
    check("midrst_no_done_pulse", n_done, 0);
    run_layer(mk(32'h0000_8000, 3, 0, 0, 1, 32'h8000, 3, 0, 0, 0, 0), 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
